// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the fetch stage and the next-PC unit.
//   fetch_state_e : fetch FSM state, 2-bit encoding
//   RESET_PC      : PC after reset, also the next-PC unit's default target
//   INSTR_NOP     : value held on the instruction output when no word is loaded
//   is_misaligned : true when an address is not word aligned
package core_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10,
        S_ERR  = 2'b11
    } fetch_state_e;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: 32-bit program counter register.
//   clk    in  : clock
//   rst    in  : asynchronous active-high reset, loads RESET_VAL
//   load_i in  : load enable, captures d_i on the rising edge
//   d_i    in  : value to load
//   q_o    out : current register value
module pc_reg #(
    parameter logic [31:0] RESET_VAL = core_pkg::RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] d_i,
    output logic [31:0] q_o
);

    logic [31:0] pc_q;

    // PC storage: reset to the boot address, otherwise load on enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VAL;
        end else if (load_i) begin
            pc_q <= d_i;
        end else begin
            pc_q <= pc_q;
        end
    end

    assign q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC-holding instruction fetch stage of the multicycle core.
//   clk, rst                 : clock, asynchronous active-high reset
//   pc_out                   : current PC, feeds the next-PC unit
//   npc_in                   : next PC, loaded only on a decode handshake
//   imem_req_valid/ready/addr: single-outstanding fetch request (addr == pc_out)
//   imem_rsp_valid/data      : fetch response, captured only while waiting
//   instr_valid/instr/ready  : fetched word handed to decode
//   fetch_err                : sticky flag, a misaligned next PC was loaded
//   fetch_count              : instructions handed to decode, wraps silently
module fetch_unit #(
    parameter logic [31:0] RESET_PC = core_pkg::RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [ADDR_W-1:0] npc_in,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    output logic [31:0]       instr,
    input  logic              instr_ready,
    output logic              fetch_err,
    output logic [31:0]       fetch_count
);

    import core_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  count_q, count_d;
    logic         instr_valid_q;
    logic         req_valid_q;
    logic         err_q;
    logic         pc_load_s;
    logic [31:0]  pc_s;

    pc_reg #(
        .RESET_VAL(RESET_PC)
    ) u_pc_reg (
        .clk    (clk),
        .rst    (rst),
        .load_i (pc_load_s),
        .d_i    (npc_in),
        .q_o    (pc_s)
    );

    // Next-state, instruction capture, PC load and counter update.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        count_d   = count_q;
        pc_load_s = 1'b0;
        case (state_q)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_d = imem_rsp_data;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_load_s = 1'b1;
                    count_d   = count_q + 32'd1;
                    // The misaligned PC is still loaded so it stays visible for debug.
                    if (is_misaligned(npc_in)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_REQ;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // State, data and registered output flags, decoded from the next state
    // so each flag lines up with the state it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_REQ;
            instr_q       <= INSTR_NOP;
            count_q       <= 32'd0;
            req_valid_q   <= 1'b1;
            instr_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            count_q       <= count_d;
            req_valid_q   <= (state_d == S_REQ);
            instr_valid_q <= (state_d == S_HOLD);
            err_q         <= (state_d == S_ERR);
        end
    end

    assign pc_out         = pc_s;
    assign imem_req_addr  = pc_s;
    assign imem_req_valid = req_valid_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign fetch_err      = err_q;
    assign fetch_count    = count_q;

endmodule
